// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store sequencer for a single-port word memory
// Sub-word stores are read-modify-write; illegal accesses never reach memory.
module lsu_mem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_LEN = 32
) (
  input  logic                d_clk,
  input  logic                d_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_LEN-1:0] mem_w_data,
  output logic                mem_rw_en,
  input  logic [DATA_LEN-1:0] mem_r_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ERR, S_RSP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic                  store_q;
  logic [DATA_LEN-1:0]   wword_q;
  logic [DATA_LEN-1:0]   rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  bad_f3;
  logic                  misaligned;
  logic                  req_illegal;
  logic [DATA_LEN-1:0]   shifted;
  logic [DATA_LEN-1:0]   load_ext;
  logic [DATA_LEN-1:0]   merged;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign accept         = req_valid && (state_q == S_IDLE);

  always_comb begin
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000: bad_f3 = 1'b0;
      3'b001: misaligned = req_addr[0];
      3'b010: misaligned = (req_addr[1:0] != 2'b00);
      3'b100: bad_f3 = req_is_store;
      3'b101: begin
        bad_f3     = req_is_store;
        misaligned = req_addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    req_illegal = bad_f3 || misaligned;
  end

  always_ff @(posedge d_clk) begin
    if (d_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_illegal)                               state_d = S_ERR;
          else if (req_is_store && req_funct3 == 3'b010) state_d = S_WR;
          else                                           state_d = S_RD;
        end
      end
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = store_q ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      S_ERR:   state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    rsp_valid  = (state_q == S_RSP);
    mem_rw_en  = (state_q == S_WR);
    mem_w_data = (state_q == S_WR) ? wword_q : '0;
  end

  assign mem_addr  = addr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Lane extraction: shift the addressed lane down to bit 0 before extending.
  always_comb begin
    shifted = mem_r_data >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = mem_r_data;
    endcase
  end

  always_comb begin
    merged = mem_r_data;
    for (int i = 0; i < 4; i++) begin
      if (f3_q[1:0] == 2'b00 && lane_q == 2'(i))
        merged[8*i +: 8] = wword_q[7:0];
      else if (f3_q[1:0] == 2'b01 && lane_q[1] == (i >= 2))
        merged[8*i +: 8] = wword_q[8*(i%2) +: 8];
    end
  end

  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      addr_q  <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr[ADDR_W+1:2];
        lane_q  <= req_addr[1:0];
        f3_q    <= req_funct3;
        store_q <= req_is_store;
        wword_q <= req_wdata;
      end
      if (state_q == S_CAP && store_q)
        wword_q <= merged;
      if (state_d == S_RSP) begin
        rdata_q <= (state_q == S_CAP && !store_q) ? load_ext : '0;
        err_q   <= (state_q == S_ERR);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed and random bench for lsu_mem_ctrl
// A byte-lane reference memory predicts every response and memory write.
module tb_lsu_mem_ctrl;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_rw_en;
  logic [31:0] mem_r_data;

  logic [31:0] mem_arr [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  always #5 d_clk = ~d_clk;

  lsu_mem_ctrl #(.ADDR_W(10), .DATA_LEN(32)) dut (
    .d_clk(d_clk), .d_rst(d_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_rw_en(mem_rw_en),
    .mem_r_data(mem_r_data)
  );

  // Data memory: registered read, Z on its output during a write, cleared by reset.
  always @(posedge d_clk) begin
    if (d_rst) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'd0;
      mem_r_data <= 32'd0;
    end else if (mem_rw_en) begin
      mem_arr[mem_addr] <= mem_w_data;
      mem_r_data        <= 'z;
    end else begin
      mem_r_data <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_illegal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal_f3, mis;
    legal_f3 = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    return !legal_f3 || mis;
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 32'h0000_00FF;
    if (f3[1:0] == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    bit          ill, er, exp_wr;
    int          lat, exp_lat, nwr, sh;
    logic [9:0]  idx, waddr;
    logic [31:0] word, val, msk, exp_rd, exp_word, wdat, rd;

    ill  = is_illegal(st, f3, a);
    idx  = a[11:2];
    sh   = 8 * int'(a[1:0]);
    word = ref_mem[idx];
    msk  = size_mask(f3) << sh;
    exp_lat = ill ? 2 : (st ? ((f3 == 3'd2) ? 2 : 4) : 3);
    exp_wr  = st && !ill;
    exp_word = (word & ~msk) | ((wd << sh) & msk);
    val = (word >> sh) & size_mask(f3);
    if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
    if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
    exp_rd = (ill || st) ? 32'd0 : val;

    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge d_clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 0; nwr = 0; waddr = '0; wdat = '0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge d_clk);
      if (mem_rw_en === 1'b1) begin
        nwr++; waddr = mem_addr; wdat = mem_w_data;
      end
      chk("ready_low_while_busy", {31'd0, req_ready}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (rsp_valid === 1'b1) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
      end
    end
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", rd, exp_rd);
    chk("rsp_err", {31'd0, er}, {31'd0, ill});
    chk("write_count", nwr, exp_wr ? 1 : 0);
    if (exp_wr) begin
      chk("write_addr", {22'd0, waddr}, {22'd0, idx});
      chk("write_data", wdat, exp_word);
      ref_mem[idx] = exp_word;
    end
    last_rd = rd;
    @(negedge d_clk);
    chk("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("mem_addr_held", {22'd0, mem_addr}, {22'd0, idx});
  endtask

  initial begin
    bit          st, hold;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    d_rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge d_clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_w_data", mem_w_data, 32'd0);
    chk("rst_mem_rw_en", {31'd0, mem_rw_en}, 32'd0);
    d_rst = 1'b0;

    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 1'b0);
    chk("tp_lw", last_rd, 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'h9, 32'h0, 1'b0);
    chk("tp_lb", last_rd, 32'hFFFFFFBE);
    do_req(1'b0, 3'd4, 32'h9, 32'h0, 1'b0);
    chk("tp_lbu", last_rd, 32'h000000BE);
    do_req(1'b0, 3'd1, 32'hA, 32'h0, 1'b0);
    chk("tp_lh", last_rd, 32'hFFFFDEAD);
    do_req(1'b0, 3'd5, 32'h8, 32'h0, 1'b0);
    chk("tp_lhu", last_rd, 32'h0000BEEF);
    do_req(1'b1, 3'd0, 32'hB, 32'hAAAA_AA12, 1'b0);
    do_req(1'b1, 3'd1, 32'h8, 32'hBBBB_5678, 1'b0);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 1'b0);
    chk("tp_merge", last_rd, 32'h12AD5678);
    do_req(1'b0, 3'd2, 32'h6, 32'h0, 1'b0);
    do_req(1'b1, 3'd1, 32'h5, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b0, 3'd3, 32'h8, 32'h0, 1'b0);
    do_req(1'b1, 3'd4, 32'h8, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'h4, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 1'b1);
    do_req(1'b1, 3'd0, 32'h4009, 32'h77, 1'b1);
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom & 32'hFFFF_F03F;
      hold = (i < 199) && ($urandom_range(0, 3) == 0);
      do_req(st, f3, a, $urandom, hold);
    end

    // Reset during the CAP cycle of a sub-word store aborts it silently.
    req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge d_clk); #1;
    req_valid = 1'b0;
    @(negedge d_clk);
    @(negedge d_clk);
    d_rst = 1'b1;
    @(negedge d_clk);
    d_rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("abort_no_write", {31'd0, mem_rw_en}, 32'd0);
      @(negedge d_clk);
    end
    do_req(1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    chk("abort_lw0", last_rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
